f_ifu: RTL and testbench
========================

F_IFU -- requirements
Module: f_ifu

Interface
REQ-001 The block SHALL have one clock and one reset: clock is clk, reset is reset, and reset is asynchronous and active-low.
REQ-002 Port list (name  direction  width  meaning) SHALL be:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- npc  in  32  next PC from the D-stage next-PC unit.
- stall  in  1  hazard unit holds F/D; current instruction not consumed this cycle.
- i_req  out  1  instruction-memory read request.
- i_addr  out  32  word address for the request, equal to F_pc.
- i_rvalid  in  1  instruction-memory response valid.
- i_rdata  in  32  instruction word returned.
- F_pc  out  32  PC of the instruction presented to D.
- F_instr  out  32  instruction presented to D.
- F_valid  out  1  F_pc/F_instr valid and consumable.
- F_adel  out  1  presented PC is misaligned or out of range.
- F_cnt  out  32  count of instructions consumed by D.
REQ-003 Constants SHALL be: PC_RESET = 0x0000_3000, IM_BASE = 0x0000_3000, IM_LIMIT = 0x0000_6FFC (last legal word).

Function
REQ-004 The FSM SHALL have three states: FETCH (issue request), WAIT (response outstanding), READY (instruction held for D).
REQ-005 In FETCH, with a legal F_pc (word-aligned and IM_BASE <= F_pc <= IM_LIMIT), the block SHALL assert i_req for exactly one cycle with i_addr = F_pc and then move to WAIT.
REQ-006 In FETCH, with an illegal F_pc, the block SHALL NOT assert i_req; it SHALL load F_instr = 0x0000_0000 (nop), set F_adel = 1, and move to READY next cycle.
REQ-007 In WAIT, i_rvalid = 1 SHALL capture i_rdata into F_instr, clear F_adel, and move to READY; otherwise the block SHALL stay in WAIT for any number of cycles.
REQ-008 i_rvalid SHALL be ignored in FETCH and READY; at most one request SHALL be outstanding.
REQ-009 F_valid SHALL be 1 exactly when the state is READY.
REQ-010 In READY with stall = 0, the block SHALL load F_pc <= npc, increment F_cnt by 1 modulo 2^32, and move to FETCH.
REQ-011 In READY with stall = 1, F_pc, F_instr, F_adel and F_cnt SHALL hold, and the state SHALL stay READY.
REQ-012 stall SHALL have no effect in FETCH or WAIT; an outstanding request always completes.
REQ-013 npc SHALL be sampled only on the READY, stall = 0 cycle; npc values in other cycles are don't-care.
REQ-014 Minimum cadence SHALL be 3 cycles per instruction with a zero-wait memory (FETCH, WAIT with i_rvalid, READY).
REQ-015 F_pc SHALL never change while F_valid = 1, so that a downstream F_pc + 4 computation is stable.
REQ-016 All outputs SHALL be driven from registers; i_req and i_addr SHALL be decoded from state and F_pc only.

Reset
REQ-017 While reset = 0, the block SHALL immediately force: state = FETCH, F_pc = PC_RESET, F_instr = 0, F_adel = 0, F_cnt = 0, F_valid = 0, i_req = 0.
REQ-018 The first i_req SHALL assert in the first cycle after reset is released, with i_addr = 0x0000_3000.
REQ-019 Reset asserted during WAIT SHALL abandon the request; instruction memory shares the reset, so no stale response follows.

Structure
REQ-020 PC_RESET, IM_BASE, IM_LIMIT and the state encodings (FETCH = 2'd0, WAIT = 2'd1, READY = 2'd2) SHALL live in the shared macro header.
REQ-021 The legality check SHALL be one combinational sub-module, f_addr_check (input pc[31:0], output legal).
REQ-022 The unused state encoding 2'd3 SHALL recover to FETCH.

Verification
REQ-023 Reset release, zero-wait memory, stall = 0, npc = F_pc + 4 -> i_addr sequence 0x3000, 0x3004, 0x3008, one request per 3 cycles; F_cnt = 3 after the third READY.
REQ-024 i_rvalid delayed 5 cycles -> state stays WAIT, F_valid = 0 for 5 cycles, then F_instr = i_rdata and F_valid = 1.
REQ-025 stall = 1 for 4 cycles in READY, with npc toggling -> F_pc, F_instr and F_cnt unchanged; after release, F_pc = npc sampled on the release cycle.
REQ-026 npc = 0x0000_3002 and, separately, npc = 0x0000_7000 -> no i_req; F_instr = 0, F_adel = 1, F_valid = 1 next cycle.
REQ-027 reset pulsed low during WAIT at F_pc = 0x3010 -> outputs reset immediately; the next request is at i_addr = 0x3000; a spurious i_rvalid in READY changes nothing.

Source files
------------

// File: rtl/f_ifu_pkg.sv
// f_ifu_pkg
// Shared constants and types for the instruction fetch unit.
//   PC_RESET / IM_BASE / IM_LIMIT : fetch address map (IM_LIMIT is the last legal word)
//   NOP_INSTR                     : instruction presented for a faulting fetch
//   state_t                       : fetch FSM encoding (2'd3 is unused and recovers to FETCH)
package f_ifu_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/f_addr_check.sv
// f_addr_check
// Combinational legality check for a fetch PC.
//   pc    : candidate fetch address
//   legal : 1 when pc is word-aligned and inside [IM_BASE, IM_LIMIT]
module f_addr_check
  import f_ifu_pkg::*;
(
  input  logic [31:0] pc,
  output logic        legal
);

  // Alignment and range are both required; IM_LIMIT is itself aligned, so
  // an aligned pc <= IM_LIMIT can never straddle the end of memory.
  assign legal = (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc <= IM_LIMIT);

endmodule

// File: rtl/f_ifu.sv
// f_ifu
// Instruction fetch unit: FETCH issues one request, WAIT holds until the
// memory answers, READY presents the instruction to D until it is consumed.
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   npc               : next PC, sampled only when D consumes (READY, stall = 0)
//   stall             : D is not consuming this cycle (only matters in READY)
//   i_req / i_addr    : instruction-memory read request and word address (= F_pc)
//   i_rvalid/i_rdata  : instruction-memory response, only honoured in WAIT
//   F_pc / F_instr    : instruction presented to D
//   F_valid           : 1 exactly in READY
//   F_adel            : presented PC was misaligned or out of range
//   F_cnt             : number of instructions consumed by D (wraps)
module f_ifu
  import f_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_adel,
  output logic [31:0] F_cnt
);

  state_t state;
  state_t next_state;
  logic   pc_legal;
  logic   consume;
  logic   capture;
  logic   fault;

  f_addr_check u_addr_check (
    .pc    (F_pc),
    .legal (pc_legal)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A legal FETCH always goes to WAIT and WAIT only leaves
  // on a response, so at most one request is ever in flight. The unused
  // encoding falls into the default and recovers to FETCH.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = pc_legal ? WAIT : READY;
      WAIT:    next_state = i_rvalid ? READY : WAIT;
      READY:   next_state = stall ? READY : FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Output decode. i_req is qualified with reset so it stays low while the
  // block is held in reset, yet rises as soon as reset is released with
  // state = FETCH and F_pc = PC_RESET already in place.
  always_comb begin
    i_req   = 1'b0;
    F_valid = 1'b0;
    consume = 1'b0;
    capture = 1'b0;
    fault   = 1'b0;
    case (state)
      FETCH: begin
        i_req = reset && pc_legal;
        fault = !pc_legal;
      end
      WAIT: begin
        capture = i_rvalid;
      end
      READY: begin
        F_valid = 1'b1;
        consume = !stall;
      end
      default: ;
    endcase
  end

  assign i_addr = F_pc;

  // Presented-instruction registers. F_pc only moves on the consume cycle,
  // which is also the cycle READY is left, so it is stable whenever
  // F_valid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      F_pc    <= PC_RESET;
      F_instr <= NOP_INSTR;
      F_adel  <= 1'b0;
      F_cnt   <= 32'd0;
    end else begin
      if (fault) begin
        F_instr <= NOP_INSTR;
        F_adel  <= 1'b1;
      end else if (capture) begin
        F_instr <= i_rdata;
        F_adel  <= 1'b0;
      end
      if (consume) begin
        F_pc  <= npc;
        F_cnt <= F_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_f_ifu.sv
// tb_f_ifu
// Directed self-checking bench for f_ifu. Inputs change 1 ns after each
// rising edge and outputs are checked at that point, well away from the edge.
module tb_f_ifu;

  logic        clk;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic        F_valid;
  logic        F_adel;
  logic [31:0] F_cnt;

  int checkCount;
  int failCount;
  logic [31:0] expCnt;
  logic [31:0] expPc;
  logic [31:0] expInstr;

  f_ifu dut (
    .clk      (clk),
    .reset    (reset),
    .npc      (npc),
    .stall    (stall),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .F_pc     (F_pc),
    .F_instr  (F_instr),
    .F_valid  (F_valid),
    .F_adel   (F_adel),
    .F_cnt    (F_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all non-reset inputs at once.
  task automatic applyStimulus(input logic [31:0] n, input logic s,
                               input logic rv, input logic [31:0] rd);
    npc      = n;
    stall    = s;
    i_rvalid = rv;
    i_rdata  = rd;
  endtask

  // One comparison, counted and reported on failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full legal fetch with a zero-wait memory; ends in READY.
  task automatic fetchZeroWait(input string tag, input logic [31:0] pc,
                               input logic [31:0] data);
    checkOutput({tag, "_req"}, {31'd0, i_req}, 32'd1);
    checkOutput({tag, "_addr"}, i_addr, pc);
    applyStimulus(32'h0, 1'b0, 1'b1, data);
    tick();
    checkOutput({tag, "_wait_valid"}, {31'd0, F_valid}, 32'd0);
    checkOutput({tag, "_wait_req"}, {31'd0, i_req}, 32'd0);
    tick();
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_rdy_valid"}, {31'd0, F_valid}, 32'd1);
    checkOutput({tag, "_rdy_instr"}, F_instr, data);
    checkOutput({tag, "_rdy_pc"}, F_pc, pc);
    checkOutput({tag, "_rdy_adel"}, {31'd0, F_adel}, 32'd0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    expCnt     = 32'd0;
    reset      = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);

    // Reset state.
    tick();
    tick();
    checkOutput("rst_pc", F_pc, 32'h0000_3000);
    checkOutput("rst_instr", F_instr, 32'h0);
    checkOutput("rst_adel", {31'd0, F_adel}, 32'd0);
    checkOutput("rst_cnt", F_cnt, 32'd0);
    checkOutput("rst_valid", {31'd0, F_valid}, 32'd0);
    checkOutput("rst_req", {31'd0, i_req}, 32'd0);

    // Release reset mid-cycle: first request must be visible immediately.
    reset = 1'b1;
    #1;

    // Straight-line run, npc = F_pc + 4, three cycles per instruction.
    expPc = 32'h0000_3000;
    for (int k = 0; k < 3; k++) begin
      expInstr = 32'hA000_0000 + k;
      fetchZeroWait("seq", expPc, expInstr);
      applyStimulus(expPc + 32'd4, 1'b0, 1'b0, 32'h0);
      tick();
      expCnt = expCnt + 32'd1;
      expPc  = expPc + 32'd4;
      checkOutput("seq_cnt", F_cnt, expCnt);
      checkOutput("seq_fetch_valid", {31'd0, F_valid}, 32'd0);
    end
    checkOutput("seq_cnt3", F_cnt, 32'd3);

    // Slow memory: response arrives after five WAIT cycles.
    checkOutput("slow_req", {31'd0, i_req}, 32'd1);
    checkOutput("slow_addr", i_addr, 32'h0000_300C);
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int j = 0; j < 5; j++) begin
      checkOutput("slow_wait_valid", {31'd0, F_valid}, 32'd0);
      checkOutput("slow_wait_req", {31'd0, i_req}, 32'd0);
      if (j == 4) applyStimulus(32'h0, 1'b1, 1'b1, 32'hBEEF_0001);
      tick();
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("slow_valid", {31'd0, F_valid}, 32'd1);
    checkOutput("slow_instr", F_instr, 32'hBEEF_0001);

    // Stall in READY for four cycles with npc toggling.
    for (int j = 0; j < 4; j++) begin
      applyStimulus((j % 2 == 0) ? 32'h0000_4000 : 32'h0000_5000, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("stall_pc", F_pc, 32'h0000_300C);
      checkOutput("stall_instr", F_instr, 32'hBEEF_0001);
      checkOutput("stall_cnt", F_cnt, expCnt);
      checkOutput("stall_valid", {31'd0, F_valid}, 32'd1);
    end
    applyStimulus(32'h0000_3010, 1'b0, 1'b0, 32'h0);
    tick();
    expCnt = expCnt + 32'd1;
    checkOutput("unstall_pc", F_pc, 32'h0000_3010);
    checkOutput("unstall_cnt", F_cnt, expCnt);
    checkOutput("unstall_valid", {31'd0, F_valid}, 32'd0);

    // Reset pulsed during WAIT at F_pc = 0x3010.
    checkOutput("rw_req", {31'd0, i_req}, 32'd1);
    checkOutput("rw_addr", i_addr, 32'h0000_3010);
    tick();
    checkOutput("rw_wait_valid", {31'd0, F_valid}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rw_pc", F_pc, 32'h0000_3000);
    checkOutput("rw_cnt", F_cnt, 32'd0);
    checkOutput("rw_instr", F_instr, 32'h0);
    checkOutput("rw_req_low", {31'd0, i_req}, 32'd0);
    tick();
    reset  = 1'b1;
    expCnt = 32'd0;
    #1;
    fetchZeroWait("post_rst", 32'h0000_3000, 32'h1234_5678);

    // Spurious response while READY must be ignored.
    applyStimulus(32'h0, 1'b1, 1'b1, 32'hDEAD_DEAD);
    tick();
    checkOutput("spur_instr", F_instr, 32'h1234_5678);
    checkOutput("spur_valid", {31'd0, F_valid}, 32'd1);
    checkOutput("spur_adel", {31'd0, F_adel}, 32'd0);

    // Misaligned, above-range, below-range and last-legal-word npc.
    applyStimulus(32'h0000_3002, 1'b0, 1'b0, 32'h0);
    tick();
    expCnt = expCnt + 32'd1;
    checkOutput("mis_req", {31'd0, i_req}, 32'd0);
    checkOutput("mis_pc", F_pc, 32'h0000_3002);
    checkOutput("mis_cnt", F_cnt, expCnt);
    applyStimulus(32'h0, 1'b0, 1'b1, 32'h5555_5555);
    tick();
    checkOutput("mis_instr", F_instr, 32'h0);
    checkOutput("mis_adel", {31'd0, F_adel}, 32'd1);
    checkOutput("mis_valid", {31'd0, F_valid}, 32'd1);

    applyStimulus(32'h0000_7000, 1'b0, 1'b0, 32'h0);
    tick();
    expCnt = expCnt + 32'd1;
    checkOutput("high_req", {31'd0, i_req}, 32'd0);
    tick();
    checkOutput("high_instr", F_instr, 32'h0);
    checkOutput("high_adel", {31'd0, F_adel}, 32'd1);
    checkOutput("high_valid", {31'd0, F_valid}, 32'd1);

    applyStimulus(32'h0000_2FFC, 1'b0, 1'b0, 32'h0);
    tick();
    expCnt = expCnt + 32'd1;
    checkOutput("low_req", {31'd0, i_req}, 32'd0);
    tick();
    checkOutput("low_adel", {31'd0, F_adel}, 32'd1);

    applyStimulus(32'h0000_6FFC, 1'b0, 1'b0, 32'h0);
    tick();
    expCnt = expCnt + 32'd1;
    fetchZeroWait("limit", 32'h0000_6FFC, 32'h0C0F_FEE0);
    checkOutput("final_cnt", F_cnt, expCnt);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
